// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO write port among NUM_REQ requesters (wr_clk domain).
// Define FIFO_WR_ARB_STATS_EN to add saturating 16-bit beat_count / stall_count outputs.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          wr_clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            grant,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [15:0]                   beat_count,
    output logic [15:0]                   stall_count
`endif
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic               owner_valid;
    logic               owner_last;
    logic               accept;
    logic               rel_burst;
    logic [PTR_W-1:0]   next_ptr;

    // One-hot of the first valid index at or above start, wrapping modulo NUM_REQ.
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                    input logic [PTR_W-1:0]   start);
        logic [NUM_REQ-1:0] pick;
        logic [PTR_W-1:0]   sel;
        int                 idx;
        pick = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(start) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            sel = PTR_W'(idx);
            if (valid[sel]) pick = NUM_REQ'(1) << sel;
        end
        return pick;
    endfunction

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        owner_valid  = |(grant_q & req_valid);
        owner_last   = |(grant_q & req_last);
        accept       = owner_valid && !fifo_full;
        rel_burst    = (accept && (owner_last || beat_cnt_q == CNT_W'(MAX_BURST - 1)))
                       || (state_q == BURST && !owner_valid && !fifo_full);

        next_ptr     = '0;
        fifo_wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                fifo_wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                next_ptr     = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end

        grant      = grant_q;
        req_ready  = grant_q & {NUM_REQ{!fifo_full}};
        fifo_wr_en = accept;
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d = rr_pick(req_valid, rr_ptr_q);
                    state_d = BURST;
                end
            end
            BURST: begin
                // Hand-over picks the next owner in the same edge; the releaser is now lowest priority.
                if (rel_burst) begin
                    rr_ptr_d   = next_ptr;
                    beat_cnt_d = '0;
                    grant_d    = rr_pick(req_valid, next_ptr);
                    state_d    = (|req_valid) ? BURST : IDLE;
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                grant_d    = '0;
                beat_cnt_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic        stall;
    logic [15:0] beat_count_q;
    logic [15:0] stall_count_q;

    assign stall = owner_valid && fifo_full;

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count_q  <= '0;
            stall_count_q <= '0;
        end else begin
            if (fifo_wr_en && beat_count_q != 16'hFFFF) beat_count_q <= beat_count_q + 16'd1;
            if (stall && stall_count_q != 16'hFFFF) stall_count_q <= stall_count_q + 16'd1;
        end
    end

    assign beat_count  = beat_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NUM_REQ=4, MAX_BURST=4, DATA_WIDTH=8).
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_fifo_wr_arbiter;

    logic        wr_clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] beat_count;
    logic [15:0] stall_count;
`endif

    int checks   = 0;
    int failures = 0;

    fifo_wr_arbiter #(
        .DATA_WIDTH (8),
        .NUM_REQ    (4),
        .MAX_BURST  (4)
    ) dut (
        .wr_clk       (wr_clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .grant        (grant),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .beat_count   (beat_count),
        .stall_count  (stall_count)
`endif
    );

    initial begin
        wr_clk = 1'b0;
        forever #5 wr_clk = ~wr_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no_finish required=finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input int idx, input logic [7:0] val);
        req_data[idx*8 +: 8] = val;
    endtask

    task automatic apply_reset();
        @(negedge wr_clk);
        rst_n = 1'b0;
        @(negedge wr_clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;

        // Reset state
        repeat (2) @(negedge wr_clk);
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_wr_en", 32'(fifo_wr_en), 32'h0);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_data", 32'(fifo_wr_data), 32'h0);
        @(negedge wr_clk);
        rst_n = 1'b1;

        // Test 1: asynchronous reset in the middle of a burst
        @(negedge wr_clk);
        req_valid = 4'b0001;
        set_data(0, 8'hA5);
        #1;
        check("t1_latency", 32'(grant), 32'h0);
        @(negedge wr_clk);
        #1;
        check("t1_grant", 32'(grant), 32'b0001);
        check("t1_wr_en", 32'(fifo_wr_en), 32'h1);
        check("t1_data", 32'(fifo_wr_data), 32'hA5);
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_grant", 32'(grant), 32'h0);
        check("t1_async_wr_en", 32'(fifo_wr_en), 32'h0);
        check("t1_async_ready", 32'(req_ready), 32'h0);
        check("t1_async_data", 32'(fifo_wr_data), 32'h0);
        @(negedge wr_clk);
        rst_n     = 1'b1;
        req_valid = 4'b0100;
        set_data(2, 8'hC3);
        #1;
        check("t1_post_rst_idle", 32'(grant), 32'h0);
        @(negedge wr_clk);
        #1;
        check("t1_regrant", 32'(grant), 32'b0100);
        check("t1_regrant_data", 32'(fifo_wr_data), 32'hC3);
        @(negedge wr_clk);
        req_valid = 4'b0000;
        #1;
        check("t1_drop_wr_en", 32'(fifo_wr_en), 32'h0);

        // Test 2: single requester streams 6 beats; forced hand-over after 4 re-grants with no bubble
        @(negedge wr_clk);
        #1;
        check("t2_idle", 32'(grant), 32'h0);
        req_valid = 4'b0001;
        set_data(0, 8'h10);
        for (int k = 0; k < 6; k++) begin
            @(negedge wr_clk);
            set_data(0, 8'(8'h10 + k));
            #1;
            check("t2_grant", 32'(grant), 32'b0001);
            check("t2_ready", 32'(req_ready), 32'b0001);
            check("t2_wr_en", 32'(fifo_wr_en), 32'h1);
            check("t2_data", 32'(fifo_wr_data), 32'(8'h10 + k));
        end
        @(negedge wr_clk);
        req_valid = 4'b0000;
        #1;
        check("t2_end_wr_en", 32'(fifo_wr_en), 32'h0);

        // Test 3: all four requesters valid, 4-beat round-robin rotation
        apply_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_data(i, 8'(8'h40 + i));
        for (int r = 0; r < 5; r++) begin
            for (int b = 0; b < 4; b++) begin
                @(negedge wr_clk);
                #1;
                check("t3_grant", 32'(grant), 32'(1) << (r % 4));
                check("t3_ready", 32'(req_ready), 32'(1) << (r % 4));
                check("t3_wr_en", 32'(fifo_wr_en), 32'h1);
                check("t3_data", 32'(fifo_wr_data), 32'(8'h40 + (r % 4)));
            end
        end
        @(negedge wr_clk);
        #1;
        check("t3_next_owner", 32'(grant), 32'b0010);
        req_valid = 4'b0000;

        // Test 4: FIFO full stalls req2 for 3 cycles after its 2nd beat
        apply_reset();
        req_valid = 4'b0100;
        set_data(2, 8'h20);
        @(negedge wr_clk);
        #1;
        check("t4_grant", 32'(grant), 32'b0100);
        check("t4_beat1", 32'(fifo_wr_data), 32'h20);
        @(negedge wr_clk);
        set_data(2, 8'h21);
        #1;
        check("t4_beat2_wr_en", 32'(fifo_wr_en), 32'h1);
        check("t4_beat2", 32'(fifo_wr_data), 32'h21);
        for (int i = 0; i < 3; i++) begin
            @(negedge wr_clk);
            fifo_full = 1'b1;
            req_valid = 4'b1100;
            set_data(2, 8'h22);
            set_data(3, 8'h30);
            #1;
            check("t4_stall_wr_en", 32'(fifo_wr_en), 32'h0);
            check("t4_stall_ready", 32'(req_ready), 32'h0);
            check("t4_stall_grant", 32'(grant), 32'b0100);
        end
        @(negedge wr_clk);
        fifo_full = 1'b0;
        #1;
        check("t4_beat3_wr_en", 32'(fifo_wr_en), 32'h1);
        check("t4_beat3", 32'(fifo_wr_data), 32'h22);
        check("t4_beat3_grant", 32'(grant), 32'b0100);
        @(negedge wr_clk);
        set_data(2, 8'h23);
        #1;
        check("t4_beat4", 32'(fifo_wr_data), 32'h23);
        check("t4_beat4_grant", 32'(grant), 32'b0100);
        @(negedge wr_clk);
        req_valid = 4'b1000;
        #1;
        check("t4_handover", 32'(grant), 32'b1000);
        check("t4_req3_data", 32'(fifo_wr_data), 32'h30);
`ifdef FIFO_WR_ARB_STATS_EN
        check("t4_stall_count", 32'(stall_count), 32'd3);
        check("t4_beat_count", 32'(beat_count), 32'd4);
`endif
        @(negedge wr_clk);
        req_valid = 4'b0000;
        #1;
        check("t4_end_wr_en", 32'(fifo_wr_en), 32'h0);

        // Test 5: req1 ends early with last on its 2nd beat
        @(negedge wr_clk);
        #1;
        check("t5_idle", 32'(grant), 32'h0);
        req_valid = 4'b1110;
        set_data(1, 8'h50);
        set_data(2, 8'h60);
        set_data(3, 8'h70);
        @(negedge wr_clk);
        #1;
        check("t5_grant", 32'(grant), 32'b0010);
        check("t5_ready", 32'(req_ready), 32'b0010);
        check("t5_beat1", 32'(fifo_wr_data), 32'h50);
        @(negedge wr_clk);
        set_data(1, 8'h51);
        req_last = 4'b0010;
        #1;
        check("t5_beat2_wr_en", 32'(fifo_wr_en), 32'h1);
        check("t5_beat2", 32'(fifo_wr_data), 32'h51);
        @(negedge wr_clk);
        req_last  = 4'b0000;
        req_valid = 4'b1100;
        #1;
        check("t5_next_grant", 32'(grant), 32'b0100);
        check("t5_next_ready", 32'(req_ready), 32'b0100);
        check("t5_next_data", 32'(fifo_wr_data), 32'h60);
        @(negedge wr_clk);
        req_valid = 4'b0000;
        #1;
        check("t5_end_wr_en", 32'(fifo_wr_en), 32'h0);

        // Test 6: owner req3 drops valid after one beat; pointer wraps to req0
        @(negedge wr_clk);
        #1;
        check("t6_idle", 32'(grant), 32'h0);
        req_valid = 4'b1001;
        set_data(3, 8'h80);
        set_data(0, 8'h90);
        @(negedge wr_clk);
        #1;
        check("t6_grant", 32'(grant), 32'b1000);
        check("t6_ready", 32'(req_ready), 32'b1000);
        check("t6_beat1", 32'(fifo_wr_data), 32'h80);
        @(negedge wr_clk);
        req_valid = 4'b0001;
        #1;
        check("t6_drop_wr_en", 32'(fifo_wr_en), 32'h0);
        check("t6_drop_grant", 32'(grant), 32'b1000);
        @(negedge wr_clk);
        #1;
        check("t6_wrap_grant", 32'(grant), 32'b0001);
        check("t6_wrap_wr_en", 32'(fifo_wr_en), 32'h1);
        check("t6_wrap_data", 32'(fifo_wr_data), 32'h90);
        @(negedge wr_clk);
        req_valid = 4'b0000;
        #1;
        check("t6_end_wr_en", 32'(fifo_wr_en), 32'h0);
        @(negedge wr_clk);
        #1;
        check("t6_final_idle", 32'(grant), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
